// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with start/busy/done handshake and an auto-reconvert-on-change mode.
module bcd_converter_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  start,
  input  logic                  auto_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [IN_WIDTH-1:0]  bin_reg;
  logic [IN_WIDTH-1:0]  last_value;
  logic [BCD_W-1:0]     bcd_acc;
  logic                 ovf_acc;
  logic [CNT_W-1:0]     count;

  logic [BCD_W-1:0]     adj_acc;
  logic [BCD_W-1:0]     next_acc;
  logic [IN_WIDTH-1:0]  next_bin;
  logic                 shift_out;
  logic                 launch;

  // Per-digit +3 correction; digits are independent, no carry between them.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

  always_comb begin
    adj_acc   = add3_digits(bcd_acc);
    next_acc  = {adj_acc[BCD_W-2:0], bin_reg[IN_WIDTH-1]};
    next_bin  = {bin_reg[IN_WIDTH-2:0], 1'b0};
    shift_out = adj_acc[BCD_W-1];
    launch    = (state != SHIFT) &&
                (start || (auto_mode && (bin_in != last_value)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      last_value <= '0;
      bin_reg    <= '0;
      bcd_acc    <= '0;
      ovf_acc    <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        SHIFT: begin
          bcd_acc <= next_acc;
          bin_reg <= next_bin;
          ovf_acc <= ovf_acc | shift_out;
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            // Final shift lands directly in the output register.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            overflow <= ovf_acc | shift_out;
            bcd_out  <= (ovf_acc | shift_out) ? ALL_NINES : next_acc;
          end
        end
        default: begin
          done <= 1'b0;
          if (launch) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            bin_reg    <= bin_in;
            last_value <= bin_in;
            bcd_acc    <= '0;
            ovf_acc    <= 1'b0;
            count      <= CNT_W'(IN_WIDTH);
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Self-checking bench: a 5-digit and a 3-digit converter share stimulus and are
// compared against an arithmetic (divide/modulo) reference model.
module tb_bcd_converter_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bin_in;
  logic        start;
  logic        auto_mode;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
  logic        busy3, done3, overflow3;
  logic [11:0] bcd_out3;

  int tests = 0;
  int fails = 0;
  logic [19:0] dq[$];

  always #5 clk = ~clk;

  bcd_converter_seq #(.IN_WIDTH(16), .DIGITS(5)) dut (
    .clock(clk), .reset(reset), .bin_in(bin_in), .start(start),
    .auto_mode(auto_mode), .busy(busy), .done(done),
    .bcd_out(bcd_out), .overflow(overflow)
  );

  bcd_converter_seq #(.IN_WIDTH(16), .DIGITS(3)) dut3 (
    .clock(clk), .reset(reset), .bin_in(bin_in), .start(start),
    .auto_mode(auto_mode), .busy(busy3), .done(done3),
    .bcd_out(bcd_out3), .overflow(overflow3)
  );

  // Record every result the 5-digit converter publishes.
  always @(posedge clk) if (done) dq.push_back(bcd_out);

  function automatic logic [31:0] ref_bcd(input int v, input int nd, output logic ovf);
    logic [31:0] r;
    int lim, p;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    r = '0;
    ovf = (v >= lim);
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (ovf) r[4*i +: 4] = 4'h9;
      else     r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion with start, wait for done, check latency and both results.
  task automatic convert(input logic [15:0] v);
    int cyc, bc;
    logic [31:0] e5, e3;
    logic o5, o3;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bc  = busy ? 1 : 0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
    end
    e5 = ref_bcd(int'(v), 5, o5);
    e3 = ref_bcd(int'(v), 3, o3);
    check("latency", cyc, 17);
    check("busy_cycles", bc, 16);
    check("bcd5", {12'd0, bcd_out}, e5);
    check("ovf5", {31'd0, overflow}, {31'd0, o5});
    check("done3", {31'd0, done3}, 1);
    check("bcd3", {20'd0, bcd_out3}, e3);
    check("ovf3", {31'd0, overflow3}, {31'd0, o3});
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 0);
    check("bcd5_hold", {12'd0, bcd_out}, e5);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int dcnt;
    logic o;
    reset = 1'b1; bin_in = '0; start = 1'b0; auto_mode = 1'b0;
    idle(3);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_bcd", {12'd0, bcd_out}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    reset = 1'b0;
    idle(2);

    convert(16'd255);
    check("bcd255", {12'd0, bcd_out}, 32'h00255);
    convert(16'd65535);
    check("bcd65535", {12'd0, bcd_out}, 32'h65535);
    convert(16'd0);
    convert(16'd999);
    check("bcd3_999", {20'd0, bcd_out3}, 32'h999);
    convert(16'd1234);
    check("ovf3_1234", {31'd0, overflow3}, 1);
    check("bcd3_1234", {20'd0, bcd_out3}, 32'h999);
    convert(16'd5);
    check("ovf3_5", {31'd0, overflow3}, 0);
    for (int i = 0; i < 8; i++) convert(16'($urandom));

    // Start while busy is ignored.
    dq.delete();
    @(negedge clk); bin_in = 16'd1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(4);
    bin_in = 16'd9999; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(30);
    check("busy_start_count", dq.size(), 1);
    check("busy_start_bcd", {12'd0, bcd_out}, 32'h01234);
    convert(16'd9999);

    // Reset in the middle of a conversion.
    dq.delete();
    @(negedge clk); bin_in = 16'd4321; start = 1'b1;
    @(negedge clk); start = 1'b0;
    idle(7);
    check("pre_rst_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_bcd", {12'd0, bcd_out}, 0);
    idle(30);
    check("abort_no_done", dq.size(), 0);

    // Auto mode: reconvert only on change; changes while busy caught afterwards.
    auto_mode = 1'b1;
    bin_in = 16'd0;
    idle(25);
    check("auto_zero_none", dq.size(), 0);
    bin_in = 16'd42;  idle(25);
    bin_in = 16'd42;  idle(25);
    bin_in = 16'd100; idle(25);
    check("auto_count", dq.size(), 2);
    if (dq.size() == 2) begin
      check("auto_first", {12'd0, dq[0]}, 32'h00042);
      check("auto_second", {12'd0, dq[1]}, 32'h00100);
    end
    dq.delete();
    bin_in = 16'd200; idle(4);
    check("auto_busy", {31'd0, busy}, 1);
    bin_in = 16'd7;   idle(50);
    dcnt = dq.size();
    check("auto_chase_count", dcnt, 2);
    if (dcnt == 2) begin
      check("auto_chase_a", {12'd0, dq[0]}, 32'h00200);
      check("auto_chase_b", {12'd0, dq[1]}, ref_bcd(7, 5, o));
    end
    auto_mode = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
